// File: rtl/cudu_pkg.sv
// ============================================================================
// Module      : cudu_pkg
// Description : Shared widths and scheduler state encoding for the cudu engine
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cudu_pkg;

    localparam int c_op_w  = 4;
    localparam int c_res_w = 8;
    localparam int c_cnt_w = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, search starts after 'last'
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import cudu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_pos = IDX_W'((int'(last) + k) % N_REQ);
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                grant[w_pos] = 1'b1;
                index        = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cudu_sched.sv
// ============================================================================
// Module      : cudu_sched
// Description : Round-robin scheduler sharing one cudu engine among requesters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cudu_sched
    import cudu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 63
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [c_op_w*N_REQ-1:0]   xin,
    input  logic [c_op_w*N_REQ-1:0]   yin,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [c_res_w-1:0]        rsp_x,
    output logic [c_res_w-1:0]        rsp_X,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      eng_start,
    output logic [c_op_w-1:0]         eng_xin,
    output logic [c_op_w-1:0]         eng_yin,
    input  logic                      eng_done,
    input  logic                      eng_ready,
    input  logic [c_res_w-1:0]        eng_x,
    input  logic [c_res_w-1:0]        eng_X
);

    localparam int                 c_iw      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    state_t              r_state, w_next;
    logic [c_iw-1:0]     r_last, r_g, w_idx;
    logic [N_REQ-1:0]    r_oh, w_grant;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_op_w-1:0]   r_xin, r_yin, w_xsel, w_ysel;
    logic [c_res_w-1:0]  r_rsp_x, r_rsp_X;
    logic                r_rsp_err, w_go, w_timeout;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_iw)
    ) u_rr_pick (
        .req   (req),
        .last  (r_last),
        .grant (w_grant),
        .index (w_idx)
    );

    assign w_go      = (|req) && eng_ready;
    assign w_timeout = (r_cnt == c_timeout);

    always_comb begin
        w_xsel = '0;
        w_ysel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_xsel = xin[i*c_op_w +: c_op_w];
                w_ysel = yin[i*c_op_w +: c_op_w];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        gnt       = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (w_go) w_next = ST_ISSUE;
            ST_ISSUE: begin
                gnt       = r_oh;
                eng_start = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT:  if (eng_done || w_timeout) w_next = ST_RESP;
            ST_RESP: begin
                rsp_valid = r_oh;
                w_next    = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last    <= c_iw'(N_REQ - 1);
            r_g       <= '0;
            r_oh      <= '0;
            r_cnt     <= '0;
            r_xin     <= '0;
            r_yin     <= '0;
            r_rsp_x   <= '0;
            r_rsp_X   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (w_go) begin
                    r_g   <= w_idx;
                    r_oh  <= w_grant;
                    r_xin <= w_xsel;
                    r_yin <= w_ysel;
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    // a done arriving in the timeout cycle still wins
                    if (eng_done) begin
                        r_rsp_x   <= eng_x;
                        r_rsp_X   <= eng_X;
                        r_rsp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_x   <= '0;
                        r_rsp_X   <= '0;
                        r_rsp_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_last <= r_g;
                default: ;
            endcase
        end
    end

    assign rsp_x   = r_rsp_x;
    assign rsp_X   = r_rsp_X;
    assign rsp_err = r_rsp_err;
    assign eng_xin = r_xin;
    assign eng_yin = r_yin;

endmodule

`default_nettype wire

// File: tb/tb_cudu_sched.sv
// ============================================================================
// Module      : tb_cudu_sched
// Description : Directed self-checking bench for cudu_sched with engine model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cudu_sched;

    localparam int N       = 4;
    localparam int TIMEOUT = 63;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [4*N-1:0] xin = '0;
    logic [4*N-1:0] yin = '0;
    logic [N-1:0]  gnt, rsp_valid;
    logic [7:0]    rsp_x, rsp_X;
    logic          rsp_err, busy, eng_start;
    logic [3:0]    eng_xin, eng_yin;
    logic          eng_done = 1'b0;
    logic          eng_ready = 1'b1;
    logic [7:0]    eng_x = '0;
    logic [7:0]    eng_X = '0;

    int checks   = 0;
    int failures = 0;
    bit eng_en   = 1'b1;

    always #5 clk = ~clk;

    cudu_sched #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .xin       (xin),
        .yin       (yin),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_x     (rsp_x),
        .rsp_X     (rsp_X),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_xin   (eng_xin),
        .eng_yin   (eng_yin),
        .eng_done  (eng_done),
        .eng_ready (eng_ready),
        .eng_x     (eng_x),
        .eng_X     (eng_X)
    );

    // Engine model: done pulses 3 cycles after start, x = a+b, X = a*b
    logic [3:0] ea = '0, eb = '0;
    int         dly = 0;
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (eng_start) begin
            ea  = eng_xin;
            eb  = eng_yin;
            dly = 3;
        end else if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0 && eng_en) begin
                eng_done = 1'b1;
                eng_x    = {4'b0, ea} + {4'b0, eb};
                eng_X    = {4'b0, ea} * {4'b0, eb};
            end
        end
    end

    task automatic apply_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int max, output logic [N-1:0] g, output int n);
        g = '0;
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (gnt != '0) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int max, output logic [N-1:0] r, output int n, output int gcnt);
        r    = '0;
        n    = 0;
        gcnt = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (gnt != '0) gcnt++;
            if (rsp_valid != '0) begin
                r = rsp_valid;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, rsp_valid, busy, eng_start} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got gnt=%b rsp_valid=%b busy=%b start=%b want all 0", gnt, rsp_valid, busy, eng_start);
        end
        checks++;
        if ({rsp_x, rsp_X, rsp_err, eng_xin, eng_yin} !== '0) begin
            failures++;
            $display("FAIL reset_data: got x=%h X=%h err=%b exin=%h eyin=%h want all 0", rsp_x, rsp_X, rsp_err, eng_xin, eng_yin);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [N-1:0] g, r;
        int n, gc;
        xin[3:0] = 4'd2;
        yin[3:0] = 4'd15;
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || eng_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gnt: got gnt=%b start=%b busy=%b want 0001 1 1", gnt, eng_start, busy);
        end
        checks++;
        if (eng_xin !== 4'd2 || eng_yin !== 4'd15) begin
            failures++;
            $display("FAIL single_operands: got %h/%h want 2/f", eng_xin, eng_yin);
        end
        req = '0;
        wait_rsp(20, r, n, gc);
        checks++;
        if (r !== 4'b0001 || n != 4 || gc != 0) begin
            failures++;
            $display("FAIL single_rsp: got rsp=%b lat=%0d extra_gnt=%0d want 0001 4 0", r, n, gc);
        end
        checks++;
        if (rsp_x !== 8'h11 || rsp_X !== 8'h1E || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_data: got x=%h X=%h err=%b want 11 1e 0", rsp_x, rsp_X, rsp_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_x !== 8'h11 || rsp_X !== 8'h1E || rsp_valid !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: got x=%h X=%h rv=%b busy=%b want 11 1e 0 0", rsp_x, rsp_X, rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, r;
        int n, gc, exp_i;
        logic [3:0] xa [N];
        logic [3:0] ya [N];
        apply_reset();
        for (int i = 0; i < N; i++) begin
            xa[i] = 4'(i + 3);
            ya[i] = 4'(2 * i + 1);
            xin[4*i +: 4] = xa[i];
            yin[4*i +: 4] = ya[i];
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_i = k % N;
            wait_gnt(10, g, n);
            checks++;
            if (g !== 4'(1 << exp_i)) begin
                failures++;
                $display("FAIL rr_gnt%0d: got %b want %b", k, g, 4'(1 << exp_i));
            end
            wait_rsp(20, r, n, gc);
            checks++;
            if (r !== 4'(1 << exp_i) || gc != 0 ||
                rsp_x !== ({4'b0, xa[exp_i]} + {4'b0, ya[exp_i]}) ||
                rsp_X !== ({4'b0, xa[exp_i]} * {4'b0, ya[exp_i]})) begin
                failures++;
                $display("FAIL rr_rsp%0d: got rsp=%b gnts=%0d x=%h X=%h want %b 0 %h %h", k, r, gc, rsp_x, rsp_X,
                         4'(1 << exp_i), {4'b0, xa[exp_i]} + {4'b0, ya[exp_i]}, {4'b0, xa[exp_i]} * {4'b0, ya[exp_i]});
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [N-1:0] g, r;
        logic [N-1:0] exp_seq [3] = '{4'b1000, 4'b0001, 4'b1000};
        int n, gc;
        apply_reset();
        req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(10, g, n);
            checks++;
            if (g !== exp_seq[k]) begin
                failures++;
                $display("FAIL wrap_gnt%0d: got %b want %b", k, g, exp_seq[k]);
            end
            req = 4'b1001;
            wait_rsp(20, r, n, gc);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0] g, r;
        int n, gc;
        xin[7:4] = 4'd9;
        yin[7:4] = 4'd3;
        eng_en = 1'b0;
        req = 4'b0010;
        wait_gnt(10, g, n);
        req = '0;
        wait_rsp(TIMEOUT + 10, r, n, gc);
        checks++;
        if (r !== 4'b0010 || n != TIMEOUT + 2) begin
            failures++;
            $display("FAIL timeout_rsp: got rsp=%b lat=%0d want 0010 %0d", r, n, TIMEOUT + 2);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_x !== 8'h00 || rsp_X !== 8'h00) begin
            failures++;
            $display("FAIL timeout_data: got err=%b x=%h X=%h want 1 00 00", rsp_err, rsp_x, rsp_X);
        end
        eng_en = 1'b1;
        @(negedge clk);
        req = 4'b0010;
        wait_gnt(10, g, n);
        req = '0;
        wait_rsp(20, r, n, gc);
        checks++;
        if (r !== 4'b0010 || n != 4 || rsp_err !== 1'b0 || rsp_x !== 8'h0C || rsp_X !== 8'h1B) begin
            failures++;
            $display("FAIL timeout_recover: got rsp=%b lat=%0d err=%b x=%h X=%h want 0010 4 0 0c 1b", r, n, rsp_err, rsp_x, rsp_X);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        logic [N-1:0] g, r;
        int n, gc, rv_seen;
        req = 4'b0100;
        wait_gnt(10, g, n);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_x !== 8'h00 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state: got busy=%b x=%h err=%b want 0 00 0", busy, rsp_x, rsp_err);
        end
        rv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) rv_seen++;
        end
        checks++;
        if (rv_seen != 0) begin
            failures++;
            $display("FAIL rstmid_late_done: got %0d active cycles want 0", rv_seen);
        end
        req = 4'b1111;
        wait_gnt(10, g, n);
        checks++;
        if (g !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_next: got %b want 0001", g);
        end
        req = '0;
        wait_rsp(20, r, n, gc);
        @(negedge clk);
    endtask

    task automatic test_not_ready();
        logic [N-1:0] g, r;
        int n, gc, early;
        eng_ready = 1'b0;
        req = 4'b0100;
        early = 0;
        repeat (5) begin
            @(negedge clk);
            if (gnt != '0 || busy) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL notready_hold: got %0d active cycles want 0", early);
        end
        eng_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL notready_gnt: got %b want 0100", gnt);
        end
        req = '0;
        wait_rsp(20, r, n, gc);
        checks++;
        if (r !== 4'b0100 || rsp_x !== 8'h0A || rsp_X !== 8'h19) begin
            failures++;
            $display("FAIL notready_rsp: got rsp=%b x=%h X=%h want 0100 0a 19", r, rsp_x, rsp_X);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_rst_mid();
        test_not_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
